pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives hold (freeze) and flush
//  (bubble) controls to PC, IF/ID, ID/EX, EX/MEM and MEM/WB from memory-busy, load-use and

---
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Inputs: hazard sources (ID regs, EX load/branch, im/dm busy).
// Outputs: pc_write, per-register hold/flush, wait_state, timeout_err.
// Optional STALL_PERF_EN adds perf_stall_cyc / perf_flush_cnt.
module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 256
`ifdef STALL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_branch_taken,
  input  logic       im_stall,
  input  logic       dm_stall,
  output logic       pc_write,
  output logic       ifid_hold,
  output logic       ifid_flush,
  output logic       idex_hold,
  output logic       idex_flush,
  output logic       exmem_hold,
  output logic       memwb_hold,
  output logic       wait_state,
  output logic       timeout_err
`ifdef STALL_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cyc
  , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          to_q, to_set;

  logic mem_busy, redirect, load_use;
  logic rs1_hit, rs2_hit, do_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      to_q    <= to_q | to_set;
    end
  end

  always_comb begin
    mem_busy = im_stall | dm_stall;
    redirect = ex_branch_taken | pend_q;
    rs1_hit  = id_use_rs1 && (id_rs1_addr == ex_rd_addr);
    rs2_hit  = id_use_rs2 && (id_rs2_addr == ex_rd_addr);
    load_use = ex_memread && (ex_rd_addr != 5'd0)
               && (rs1_hit || rs2_hit);
    do_redir = !mem_busy && redirect;

    state_d = mem_busy ? S_WAIT : S_RUN;

    // A redirect seen under a stall is replayed on release.
    pend_d = pend_q;
    if (ex_branch_taken && mem_busy)
      pend_d = 1'b1;
    else if (do_redir)
      pend_d = 1'b0;

    // cnt_q is the number of busy cycles before this one
    // in the current episode, capped at MAX_WAIT.
    cnt_d = '0;
    if (mem_busy)
      cnt_d = (cnt_q == WMAX) ? cnt_q : cnt_q + 1'b1;
    to_set = mem_busy && (cnt_q == WMAX);

    pc_write    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    memwb_hold  = 1'b0;
    wait_state  = 1'b0;
    timeout_err = 1'b0;

    if (!rst) begin
      wait_state  = (state_q == S_WAIT);
      timeout_err = to_q | to_set;
      if (mem_busy) begin
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
        memwb_hold = 1'b1;
      end else if (redirect) begin
        pc_write   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_write)
        perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (do_redir)
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
